uart_rx_mmio: RTL and testbench

Memory-mapped UART receiver with a receive FIFO. It is the host-to-CPU counterpart of the `to_host` transmit path. The block oversamples `rxd` at `SERIAL_WCNT` clocks per bit and deframes 8N1 bytes into a FIFO. The CPU drains the FIFO, and reads error and occupancy status, through two read-only MMIO offsets in the `0xf` region, alongside the TX register at offset `0x0100`.

---
 rtl/uart_rx_mmio.sv | 156 +++++++++++++++
 tb/tb_uart_rx_mmio.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_mmio.sv
// Oversampling 8N1 UART receiver feeding a small FIFO, drained by the CPU
// through read-only MMIO DATA (0x0104) and STATUS (0x0108) registers.
module uart_rx_mmio #(
  parameter int SERIAL_WCNT = 120,
  parameter int FIFO_LOG    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        mmio_oe,
  input  logic [15:0] mmio_addr,
  output logic [31:0] mmio_rdata,
  output logic        mmio_valid,
  output logic        rx_avail
);

  localparam int BW    = $clog2(SERIAL_WCNT);
  localparam int DEPTH = 2 ** FIFO_LOG;
  localparam logic [BW-1:0] HALF_M1 = BW'(SERIAL_WCNT / 2 - 1);
  localparam logic [BW-1:0] FULL_M1 = BW'(SERIAL_WCNT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t            r_state;
  logic [1:0]        r_sync;
  logic [BW-1:0]     r_bcnt;
  logic [2:0]        r_bidx;
  logic [7:0]        r_shift;
  logic [7:0]        r_mem [DEPTH];
  logic [FIFO_LOG:0] r_wp, r_rp;
  logic              r_ovr, r_ferr;
  logic              r_valid;
  logic [31:0]       r_rdata;

  logic              w_rxs, w_bit_end, w_stop_smp, w_push, w_ferr_evt;
  logic [FIFO_LOG:0] w_count;
  logic              w_empty, w_full, w_rd_data, w_rd_stat, w_pop, w_wr, w_ovr_evt;
  logic [7:0]        w_count8;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], rxd};
  end

  assign w_rxs = r_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_bcnt  <= '0;
      r_bidx  <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_rxs) begin
            r_bcnt  <= HALF_M1;
            r_state <= START;
          end
        end
        START: begin
          if (r_bcnt == '0) begin
            if (w_rxs) begin
              r_state <= IDLE;
            end else begin
              r_bcnt  <= FULL_M1;
              r_bidx  <= '0;
              r_state <= DATA;
            end
          end else begin
            r_bcnt <= r_bcnt - 1'b1;
          end
        end
        DATA: begin
          if (r_bcnt == '0) begin
            r_shift <= {w_rxs, r_shift[7:1]};
            r_bcnt  <= FULL_M1;
            r_bidx  <= r_bidx + 3'd1;
            if (r_bidx == 3'd7) r_state <= STOP;
          end else begin
            r_bcnt <= r_bcnt - 1'b1;
          end
        end
        STOP: begin
          if (r_bcnt == '0) r_state <= w_rxs ? IDLE : BREAK;
          else              r_bcnt  <= r_bcnt - 1'b1;
        end
        BREAK: begin
          if (r_bcnt != '0) r_bcnt  <= r_bcnt - 1'b1;
          if (w_rxs)        r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_bit_end  = (r_bcnt == '0);
  assign w_stop_smp = (r_state == STOP) && w_bit_end;
  assign w_push     = w_stop_smp && w_rxs;
  assign w_ferr_evt = w_stop_smp && !w_rxs;

  assign w_count   = r_wp - r_rp;
  assign w_empty   = (w_count == '0);
  assign w_full    = (w_count == (FIFO_LOG + 1)'(DEPTH));
  assign w_rd_data = mmio_oe && (mmio_addr == 16'h0104);
  assign w_rd_stat = mmio_oe && (mmio_addr == 16'h0108);
  assign w_pop     = w_rd_data && !w_empty;
  // A full FIFO still accepts a push when the same edge pops the head slot.
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovr_evt = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp[FIFO_LOG-1:0]] <= r_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_wr)  r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_ovr  <= w_ovr_evt  || (r_ovr  && !w_rd_stat);
      r_ferr <= w_ferr_evt || (r_ferr && !w_rd_stat);
    end
  end

  always_comb begin
    w_count8 = '0;
    w_count8[FIFO_LOG:0] = w_count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_valid <= mmio_oe;
      if (mmio_oe) begin
        if (w_rd_data)
          r_rdata <= w_empty ? '1 : {24'h0, r_mem[r_rp[FIFO_LOG-1:0]]};
        else if (w_rd_stat)
          r_rdata <= {16'h0, w_count8, 6'h0, r_ovr, r_ferr};
        else
          r_rdata <= '0;
      end
    end
  end

  assign mmio_valid = r_valid;
  assign mmio_rdata = r_rdata;
  assign rx_avail   = !w_empty;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio with 8 clocks per bit and a 4-entry FIFO.
module tb_uart_rx_mmio;

  localparam int W = 8;

  logic        clk, rst, rxd, mmio_oe;
  logic [15:0] mmio_addr;
  logic [31:0] mmio_rdata;
  logic        mmio_valid, rx_avail;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          rise;
  logic [31:0] d, prev;
  logic [7:0]  exp_q [4];

  uart_rx_mmio #(.SERIAL_WCNT(W), .FIFO_LOG(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .mmio_oe    (mmio_oe),
    .mmio_addr  (mmio_addr),
    .mmio_rdata (mmio_rdata),
    .mmio_valid (mmio_valid),
    .rx_avail   (rx_avail)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    int idx;
    idx = k / W;
    if (idx == 0)      return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else               return 1'b1;
  endfunction

  // Called on a negedge; rise = first negedge index (1-based) where rx_avail is high.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len,
                            output int rise_o);
    rise_o = 0;
    for (int k = 0; k < 9 * W + stop_len; k++) begin
      rxd = (k < 9 * W) ? frame_bit(b, k) : stop;
      @(negedge clk);
      if (rise_o == 0 && rx_avail) rise_o = k + 1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int r;
    send_frame(b, 1'b1, W, r);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic mmio_rd(input logic [15:0] a, output logic [31:0] dat);
    mmio_oe   = 1'b1;
    mmio_addr = a;
    @(negedge clk);
    mmio_oe = 1'b0;
    check("valid", {31'b0, mmio_valid}, 32'h1);
    dat = mmio_rdata;
  endtask

  initial begin
    rst = 1'b1; rxd = 1'b1; mmio_oe = 1'b0; mmio_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'b0, mmio_valid}, 32'h0);
    check("rst_rdata", mmio_rdata, 32'h0);
    check("rst_avail", {31'b0, rx_avail}, 32'h0);
    rst = 1'b0;
    idle(4);

    // Single frame, exact rx_avail timing, pop, then empty read
    send_frame(8'hA5, 1'b1, W, rise);
    check("a5_rise", 32'(rise), 32'd79);
    mmio_rd(16'h0104, d); check("a5_data", d, 32'h000000A5);
    prev = d;
    check("a5_avail_low", {31'b0, rx_avail}, 32'h0);
    @(negedge clk);
    check("valid_drop", {31'b0, mmio_valid}, 32'h0);
    check("rdata_hold", mmio_rdata, prev);
    mmio_rd(16'h0104, d); check("a5_empty", d, 32'hFFFFFFFF);
    mmio_rd(16'h0000, d); check("other_addr", d, 32'h0);

    // Back-to-back frames, consecutive reads
    exp_q = '{8'h00, 8'hFF, 8'h55, 8'h3C};
    for (int i = 0; i < 4; i++) send(exp_q[i]);
    idle(2);
    mmio_rd(16'h0108, d); check("b2b_stat4", d, 32'h00000400);
    mmio_oe = 1'b1; mmio_addr = 16'h0104;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_valid", {31'b0, mmio_valid}, 32'h1);
      check("b2b_data", mmio_rdata, {24'h0, exp_q[i]});
    end
    mmio_oe = 1'b0;
    mmio_rd(16'h0108, d); check("b2b_stat0", d, 32'h00000000);

    // Overrun: six frames into four entries
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) send(exp_q[i]);
    send(8'h55); send(8'h66);
    idle(2);
    mmio_rd(16'h0108, d); check("ovr_stat", d, 32'h00000402);
    mmio_rd(16'h0108, d); check("ovr_clear", d, 32'h00000400);
    for (int i = 0; i < 4; i++) begin
      mmio_rd(16'h0104, d); check("ovr_data", d, {24'h0, exp_q[i]});
    end
    mmio_rd(16'h0104, d); check("ovr_empty", d, 32'hFFFFFFFF);

    // Framing error with line held low, then recovery
    send_frame(8'h7E, 1'b0, 30, rise);
    check("ferr_nopush", 32'(rise), 32'd0);
    idle(16);
    check("ferr_avail", {31'b0, rx_avail}, 32'h0);
    mmio_rd(16'h0108, d); check("ferr_stat", d, 32'h00000001);
    send(8'h81);
    idle(2);
    mmio_rd(16'h0104, d); check("ferr_recover", d, 32'h00000081);
    mmio_rd(16'h0108, d); check("ferr_cleared", d, 32'h00000000);

    // Short glitch rejected as false start
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    idle(20);
    check("glitch_avail", {31'b0, rx_avail}, 32'h0);
    mmio_rd(16'h0108, d); check("glitch_stat", d, 32'h00000000);

    // Reset during data bit 4 with two bytes queued
    send(8'h12); send(8'h34);
    for (int k = 0; k < 5 * W + 4; k++) begin
      rxd = frame_bit(8'h99, k);
      @(negedge clk);
    end
    rst = 1'b1; rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_avail", {31'b0, rx_avail}, 32'h0);
    rst = 1'b0;
    idle(4);
    mmio_rd(16'h0108, d); check("mid_rst_stat", d, 32'h00000000);
    mmio_rd(16'h0104, d); check("mid_rst_empty", d, 32'hFFFFFFFF);
    send(8'h42);
    idle(2);
    mmio_rd(16'h0104, d); check("mid_rst_42", d, 32'h00000042);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
